// File: rtl/decode_stage.sv
// Instruction-decode stage: register file with write-through bypass, load-use hazard
// detection, ID/EX pipeline register and a saturating stall-cycle counter.
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [4:0]        OPcode,
  input  logic [2:0]        ALUop,
  input  logic [4:0]        Rs1,
  input  logic [4:0]        Rs2,
  input  logic [4:0]        Rd,
  input  logic [15:0]       Imm,
  input  logic [26:0]       Address,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rd,
  input  logic              wb_we,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              id_valid,
  output logic [4:0]        id_opcode,
  output logic [2:0]        id_aluop,
  output logic [4:0]        id_rs1,
  output logic [4:0]        id_rs2,
  output logic [4:0]        id_rd,
  output logic [DATA_W-1:0] id_rs1_data,
  output logic [DATA_W-1:0] id_rs2_data,
  output logic [DATA_W-1:0] id_imm,
  output logic [26:0]       id_address,
  output logic [CNT_W-1:0]  stall_count
);

  logic [DATA_W-1:0] rf [32];
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;
  logic              wb_hit;
  logic              hz;

  assign wb_hit = wb_we && (wb_rd != 5'd0);

  // Write-through: a same-cycle write-back is visible to the read in decode.
  always_comb begin
    rs1_val = rf[Rs1];
    rs2_val = rf[Rs2];
    if (wb_hit && (wb_rd == Rs1)) rs1_val = wb_data;
    if (wb_hit && (wb_rd == Rs2)) rs2_val = wb_data;
    if (Rs1 == 5'd0) rs1_val = '0;
    if (Rs2 == 5'd0) rs2_val = '0;
  end

  assign hz = in_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
              ((ex_rd == Rs1) || (ex_rd == Rs2));
  assign stall = hz && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_hit) begin
      rf[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid    <= 1'b0;
      id_opcode   <= '0;
      id_aluop    <= '0;
      id_rs1      <= '0;
      id_rs2      <= '0;
      id_rd       <= '0;
      id_rs1_data <= '0;
      id_rs2_data <= '0;
      id_imm      <= '0;
      id_address  <= '0;
    end else if (flush || stall) begin
      id_valid    <= 1'b0;
      id_opcode   <= '0;
      id_aluop    <= '0;
      id_rs1      <= '0;
      id_rs2      <= '0;
      id_rd       <= '0;
      id_rs1_data <= '0;
      id_rs2_data <= '0;
      id_imm      <= '0;
      id_address  <= '0;
    end else begin
      id_valid    <= in_valid;
      id_opcode   <= OPcode;
      id_aluop    <= ALUop;
      id_rs1      <= Rs1;
      id_rs2      <= Rs2;
      id_rd       <= Rd;
      id_rs1_data <= rs1_val;
      id_rs2_data <= rs2_val;
      id_imm      <= {{(DATA_W-16){Imm[15]}}, Imm};
      id_address  <= Address;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage: a driver predicts each ID/EX update from a
// behavioural model and queues it; a monitor pops and compares after every rising edge.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [4:0]  OPcode;
  logic [2:0]  ALUop;
  logic [4:0]  Rs1, Rs2, Rd;
  logic [15:0] Imm;
  logic [26:0] Address;
  logic        flush, ex_valid, ex_mem_read;
  logic [4:0]  ex_rd;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        stall, id_valid;
  logic [4:0]  id_opcode, id_rs1, id_rs2, id_rd;
  logic [2:0]  id_aluop;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic [26:0] id_address;
  logic [15:0] stall_count;

  logic        s_stall, s_id_valid;
  logic [4:0]  s_id_opcode, s_id_rs1, s_id_rs2, s_id_rd;
  logic [2:0]  s_id_aluop;
  logic [31:0] s_id_rs1_data, s_id_rs2_data, s_id_imm;
  logic [26:0] s_id_address;
  logic [1:0]  s_stall_count;

  decode_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .OPcode(OPcode), .ALUop(ALUop),
    .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Imm(Imm), .Address(Address), .flush(flush),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .stall(stall), .id_valid(id_valid),
    .id_opcode(id_opcode), .id_aluop(id_aluop), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_address(id_address), .stall_count(stall_count)
  );

  // Narrow-counter instance to reach saturation quickly.
  decode_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .OPcode(OPcode), .ALUop(ALUop),
    .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd), .Imm(Imm), .Address(Address), .flush(flush),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .stall(s_stall), .id_valid(s_id_valid),
    .id_opcode(s_id_opcode), .id_aluop(s_id_aluop), .id_rs1(s_id_rs1), .id_rs2(s_id_rs2),
    .id_rd(s_id_rd), .id_rs1_data(s_id_rs1_data), .id_rs2_data(s_id_rs2_data),
    .id_imm(s_id_imm), .id_address(s_id_address), .stall_count(s_stall_count)
  );

  typedef struct packed {
    logic        valid;
    logic [4:0]  opcode;
    logic [2:0]  aluop;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_data, rs2_data, imm;
    logic [26:0] address;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mregs [32];
  int          mcnt, mcnt2;
  int          checks, errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (wb_we && wb_rd != 5'd0 && wb_rd == idx) return wb_data;
    return mregs[idx];
  endfunction

  task automatic idle();
    in_valid = 0; OPcode = 0; ALUop = 0; Rs1 = 0; Rs2 = 0; Rd = 0; Imm = 0; Address = 0;
    flush = 0; ex_valid = 0; ex_mem_read = 0; ex_rd = 0; wb_we = 0; wb_rd = 0; wb_data = 0;
  endtask

  // Called at a falling edge with inputs already applied; predicts the next rising edge.
  task automatic step();
    logic hz, st;
    exp_t e;
    #1;
    hz = in_valid && ex_valid && ex_mem_read && ex_rd != 5'd0 && (ex_rd == Rs1 || ex_rd == Rs2);
    st = hz && !flush;
    chk("stall", {63'd0, stall}, {63'd0, st});
    e = '0;
    if (!st && !flush) begin
      e.valid    = in_valid;
      e.opcode   = OPcode;
      e.aluop    = ALUop;
      e.rs1      = Rs1;
      e.rs2      = Rs2;
      e.rd       = Rd;
      e.rs1_data = rd_model(Rs1);
      e.rs2_data = rd_model(Rs2);
      e.imm      = {{16{Imm[15]}}, Imm};
      e.address  = Address;
    end
    if (st) begin
      if (mcnt < 65535) mcnt++;
      if (mcnt2 < 3) mcnt2++;
    end
    e.cnt  = 16'(mcnt);
    e.cnt2 = 2'(mcnt2);
    q.push_back(e);
    if (wb_we && wb_rd != 5'd0) mregs[wb_rd] = wb_data;
    @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mcnt = 0;
    mcnt2 = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("id_valid", {63'd0, id_valid}, {63'd0, e.valid});
        chk("id_opcode", {59'd0, id_opcode}, {59'd0, e.opcode});
        chk("id_aluop", {61'd0, id_aluop}, {61'd0, e.aluop});
        chk("id_rs1", {59'd0, id_rs1}, {59'd0, e.rs1});
        chk("id_rs2", {59'd0, id_rs2}, {59'd0, e.rs2});
        chk("id_rd", {59'd0, id_rd}, {59'd0, e.rd});
        chk("id_rs1_data", {32'd0, id_rs1_data}, {32'd0, e.rs1_data});
        chk("id_rs2_data", {32'd0, id_rs2_data}, {32'd0, e.rs2_data});
        chk("id_imm", {32'd0, id_imm}, {32'd0, e.imm});
        chk("id_address", {37'd0, id_address}, {37'd0, e.address});
        chk("stall_count", {48'd0, stall_count}, {48'd0, e.cnt});
        chk("stall_count_sat", {62'd0, s_stall_count}, {62'd0, e.cnt2});
      end
    end
  end

  task automatic rand_cycle();
    in_valid = ($urandom_range(0, 3) != 0);
    OPcode = 5'($urandom); ALUop = 3'($urandom);
    Rs1 = 5'($urandom); Rs2 = 5'($urandom); Rd = 5'($urandom);
    Imm = 16'($urandom); Address = 27'($urandom);
    flush = ($urandom_range(0, 7) == 0);
    ex_valid = ($urandom_range(0, 3) != 0);
    ex_mem_read = $urandom_range(0, 1) == 1;
    case ($urandom_range(0, 3))
      0: ex_rd = Rs1;
      1: ex_rd = Rs2;
      default: ex_rd = 5'($urandom);
    endcase
    wb_we = $urandom_range(0, 1) == 1;
    wb_rd = ($urandom_range(0, 2) == 0) ? Rs1 : 5'($urandom);
    wb_data = $urandom;
    step();
  endtask

  initial begin : driver
    checks = 0;
    errors = 0;
    model_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Warm up with random traffic so reset has state to clear.
    repeat (40) rand_cycle();

    // Asynchronous reset mid-cycle.
    idle();
    #2 rst = 1'b1;
    #1;
    chk("rst_id_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_id_bus", {id_rs1_data, id_rs2_data}, 64'd0);
    chk("rst_id_fields", {5'd0, id_imm, id_address}, 64'd0);
    chk("rst_id_idx", {41'd0, id_opcode, id_aluop, id_rs1, id_rs2, id_rd}, 64'd0);
    chk("rst_stall_count", {48'd0, stall_count}, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // r0 write ignored, r0 reads zero.
    idle(); wb_we = 1; wb_rd = 0; wb_data = 32'hDEADBEEF; step();
    idle(); in_valid = 1; Rs1 = 0; Rs2 = 0; step();

    // Plain decode after writing r5.
    idle(); wb_we = 1; wb_rd = 5; wb_data = 32'h11; step();
    idle(); in_valid = 1; OPcode = 5'h03; ALUop = 3'h2; Rs1 = 5; Rs2 = 0; Rd = 7;
    Imm = 16'hFFFE; step();

    // Same-cycle bypass.
    idle(); in_valid = 1; Rs2 = 9; wb_we = 1; wb_rd = 9; wb_data = 32'h1234; step();

    // Load-use stall then release.
    idle(); in_valid = 1; Rs1 = 4; Rd = 2; ex_valid = 1; ex_mem_read = 1; ex_rd = 4; step();
    ex_mem_read = 0; step();

    // Flush beats stall.
    idle(); in_valid = 1; Rs1 = 4; ex_valid = 1; ex_mem_read = 1; ex_rd = 4; flush = 1; step();

    // Hold the hazard to saturate the narrow counter.
    idle(); in_valid = 1; Rs2 = 12; ex_valid = 1; ex_mem_read = 1; ex_rd = 12;
    repeat (6) step();

    repeat (400) rand_cycle();

    idle();
    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
